// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transmit scheduler: word width, scheduler
// state encoding and a constant-friendly ceil(log2) helper.
package spi_pkg;

  localparam int SPI_DATA_W = 24;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    START   = 2'b10,
    DRAIN   = 2'b11
  } sched_state_t;

  // Never returns less than 1 so that a 1-entry index still has a real bit.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/spi_tx_scheduler_if.sv
// Bundle of requester, FIFO-write and transmitter-control signals around the
// scheduler. The master modport is the scheduler; slave is its surroundings.
interface spi_tx_scheduler_if
  import spi_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = SPI_DATA_W,
  parameter int IDX_W   = clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]        i_req;
  logic [NUM_REQ*DATA_W-1:0] i_reqData;
  logic [NUM_REQ-1:0]        o_reqAck;
  logic                      i_fifoFull;
  logic                      i_fifoEmpty;
  logic                      o_fifoWr;
  logic [DATA_W-1:0]         o_fifoWdata;
  logic                      i_spiBusy;
  logic                      o_startTransmit;
  logic [IDX_W-1:0]          o_grantId;
  logic                      o_schedBusy;

  modport master (
    input  i_req, i_reqData, i_fifoFull, i_fifoEmpty, i_spiBusy,
    output o_reqAck, o_fifoWr, o_fifoWdata, o_startTransmit, o_grantId, o_schedBusy
  );

  modport slave (
    output i_req, i_reqData, i_fifoFull, i_fifoEmpty, i_spiBusy,
    input  o_reqAck, o_fifoWr, o_fifoWdata, o_startTransmit, o_grantId, o_schedBusy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational requester arbiter: round-robin from i_ptr by default, or fixed
// lowest-index priority when SPI_SCHED_FIXED_PRIO_EN is defined.
module rr_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  localparam int SUM_W = IDX_W + 1;

`ifdef SPI_SCHED_FIXED_PRIO_EN
  logic w_unusedPtr;
  assign w_unusedPtr = ^i_ptr;

  always_comb begin
    o_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = IDX_W'(i);
      end
    end
  end
`else
  logic [2*NUM_REQ-1:0] w_doubled;
  logic [NUM_REQ-1:0]   w_rotated;

  // Rotating the request vector right by i_ptr makes "first at or after the
  // pointer" become "lowest set bit", then the offset is mapped back.
  assign w_doubled = {i_req, i_req} >> i_ptr;
  assign w_rotated = w_doubled[NUM_REQ-1:0];

  always_comb begin
    logic [SUM_W-1:0] w_sum;
    o_idx = '0;
    w_sum = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rotated[k]) begin
        w_sum = {1'b0, i_ptr} + SUM_W'(k);
        if (w_sum >= SUM_W'(NUM_REQ)) begin
          w_sum = w_sum - SUM_W'(NUM_REQ);
        end
        o_idx = w_sum[IDX_W-1:0];
      end
    end
  end
`endif

  assign o_valid = |i_req;

  always_comb begin
    o_grant = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      o_grant[j] = o_valid && (o_idx == IDX_W'(j));
    end
  end

endmodule

// File: rtl/spi_tx_scheduler.sv
// Collects requester words into the shared SPI TX FIFO in bursts, then holds
// start_transmit until the burst drains. SPI_SCHED_FIXED_PRIO_EN selects fixed priority.
module spi_tx_scheduler
  import spi_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = SPI_DATA_W,
  parameter int BURST_MAX = 8
) (
  input logic                clock,
  input logic                reset,
  spi_tx_scheduler_if.master bus
);

  localparam int IDX_W = clog2(NUM_REQ);
  localparam int CNT_W = clog2(BURST_MAX + 1);

  sched_state_t r_state;
  sched_state_t w_nextState;

  logic [CNT_W-1:0]   r_burstCnt;
  logic [CNT_W-1:0]   w_cntAfter;
  logic [IDX_W-1:0]   r_grantId;
  logic [IDX_W-1:0]   w_ptr;
  logic [IDX_W-1:0]   w_grantIdx;
  logic [IDX_W-1:0]   w_nextPtr;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_grantValid;
  logic               w_anyReq;
  logic               w_burstRoom;
  logic               w_doGrant;
  logic [NUM_REQ-1:0] w_reqAck;
  logic [DATA_W-1:0]  w_fifoWdata;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arbiter (
    .i_req   (bus.i_req),
    .i_ptr   (w_ptr),
    .o_grant (w_grant),
    .o_idx   (w_grantIdx),
    .o_valid (w_grantValid)
  );

  assign w_anyReq    = |bus.i_req;
  assign w_burstRoom = r_burstCnt < CNT_W'(BURST_MAX);
  assign w_doGrant   = (r_state == COLLECT) && w_grantValid && !bus.i_fifoFull && w_burstRoom;
  assign w_nextPtr   = (w_grantIdx == IDX_W'(NUM_REQ - 1)) ? '0 : w_grantIdx + IDX_W'(1);

`ifdef SPI_SCHED_FIXED_PRIO_EN
  logic [IDX_W-1:0] w_unusedNextPtr;
  assign w_unusedNextPtr = w_nextPtr;
  assign w_ptr           = '0;
`else
  logic [IDX_W-1:0] r_rrPtr;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rrPtr <= '0;
    end else if (w_doGrant) begin
      r_rrPtr <= w_nextPtr;
    end
  end

  assign w_ptr = r_rrPtr;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // The burst count only resets when a drained burst hands back to IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_burstCnt <= '0;
      r_grantId  <= '0;
    end else if (w_doGrant) begin
      r_burstCnt <= w_cntAfter;
      r_grantId  <= w_grantIdx;
    end else if (r_state == DRAIN && w_nextState == IDLE) begin
      r_burstCnt <= '0;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_cntAfter  = r_burstCnt + CNT_W'(w_doGrant);
    case (r_state)
      IDLE: begin
        if (w_anyReq || bus.i_fifoFull) begin
          w_nextState = COLLECT;
        end
      end
      COLLECT: begin
        if (w_cntAfter == CNT_W'(BURST_MAX) || bus.i_fifoFull ||
            (!w_anyReq && r_burstCnt != '0)) begin
          w_nextState = START;
        end
      end
      START: begin
        if (bus.i_spiBusy) begin
          w_nextState = DRAIN;
        end
      end
      DRAIN: begin
        // A low spi_busy with words still queued is only an inter-word gap.
        if (bus.i_fifoEmpty && !bus.i_spiBusy) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_reqAck    = '0;
    w_fifoWdata = '0;
    if (w_doGrant) begin
      w_reqAck = w_grant;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_grant[i]) begin
          w_fifoWdata = bus.i_reqData[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign bus.o_reqAck        = w_reqAck;
  assign bus.o_fifoWr        = w_doGrant;
  assign bus.o_fifoWdata     = w_fifoWdata;
  assign bus.o_startTransmit = (r_state == START) || (r_state == DRAIN);
  assign bus.o_grantId       = r_grantId;
  assign bus.o_schedBusy     = (r_state != IDLE);

endmodule

// File: doc/spi_tx_scheduler.md
Name: spi_tx_scheduler

Overview:
Shares the single 24-bit SPI transmitter (and its input FIFO) between NUM_REQ independent requesters, e.g. per-channel DAC update sources.
Collects words from requesters into the TX FIFO in bursts, using round-robin arbitration by default.
Then holds start_transmit until the burst has fully shifted out.
Sits between the requester logic and the FIFO write port; monitors the transmitter's spi_busy and the FIFO's fifo_empty/fifo_full.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_W, 24, word width; must match the transmitter
BURST_MAX, 8, maximum words pushed per burst; must not exceed FIFO depth

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester word-valid; held until acked
req_data  in  NUM_REQ*DATA_W  requester i word at bits [i*DATA_W +: DATA_W]
req_ack  out  NUM_REQ  one-hot; word accepted at this clock edge
fifo_full  in  1  TX FIFO full
fifo_empty  in  1  TX FIFO empty
fifo_wr  out  1  FIFO write strobe
fifo_wdata  out  DATA_W  FIFO write data
spi_busy  in  1  transmitter busy
start_transmit  out  1  transmit enable to the transmitter
grant_id  out  $clog2(NUM_REQ)  index of the last granted requester
sched_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: req_ack=0, fifo_wr=0, fifo_wdata=0, start_transmit=0, grant_id=0, sched_busy=0, state=IDLE, rr pointer=0, burst_cnt=0.
- Reset mid-burst abandons the burst. Words already in the FIFO are not flushed; the FIFO owner handles that.
- States: IDLE, COLLECT, START, DRAIN.
- IDLE: if any req, go to COLLECT next cycle. Nothing is granted in IDLE.
- COLLECT grant condition: grant when (any req) & ~fifo_full & (burst_cnt<BURST_MAX).
- Grant selection: the first asserted req at or after the rr pointer, wrapping modulo NUM_REQ.
- Grant actions, all in the same cycle (combinational from registered state and inputs):
  - fifo_wr=1 and fifo_wdata = the granted word.
  - req_ack[g]=1.
  - At the edge: burst_cnt+1, rr pointer=(g+1) mod NUM_REQ, grant_id=g.
- Throughput: one word per cycle maximum. A requester samples ack at the edge and may present its next word in the following cycle.
- Leave COLLECT for START when burst_cnt==BURST_MAX, or fifo_full, or (no req & burst_cnt>0). This is evaluated after any grant in the current cycle.
- START: start_transmit=1. No grants. Go to DRAIN on the first cycle spi_busy=1.
- DRAIN: start_transmit stays 1 so the transmitter keeps refilling from the FIFO. No grants.
  - When fifo_empty & ~spi_busy, go to IDLE and clear burst_cnt. start_transmit drops in the same cycle the state becomes IDLE.
- Inter-word gaps: spi_busy low with fifo_empty low is a normal gap between words and does not end DRAIN.
- Requests arriving during START/DRAIN are held off and served in the next burst.
- Simultaneous requests: exactly one grant per cycle; req_ack is never multi-hot.
- fifo_full while in IDLE: go to COLLECT, which then exits to START with burst_cnt=0. This is a legal zero-word burst that drains the pre-existing FIFO contents.

Optional Feature:
SPI_SCHED_FIXED_PRIO_EN
- Defined: fixed priority, lowest index wins; the rr pointer is removed and grant_id still reports the winner.
- Undefined: round-robin as above.

Decomposition:
- Shared package spi_pkg holds:
  - SPI_DATA_W=24
  - state encodings IDLE=2'b00, COLLECT=2'b01, START=2'b10, DRAIN=2'b11
  - a clog2 helper
- One sub-module: rr_arbiter (NUM_REQ; inputs req and ptr; outputs one-hot grant, index and valid).
  - Purely combinational.
  - Contains both the round-robin and fixed-priority variants under the macro.

Test Plan:
- Single requester 1 holds 3 words (0xA00001..0xA00003) -> three consecutive fifo_wr cycles with req_ack=0010; START, then DRAIN; start_transmit stays high until 72 sclk periods complete and fifo_empty & ~spi_busy; then sched_busy=0.
- All 4 req high continuously, BURST_MAX=8 -> grant order 0,1,2,3,0,1,2,3; exit to START after the 8th word; no acks until back in IDLE.
- fifo_full asserted after the 2nd push -> no further fifo_wr; go to START with burst_cnt=2; remaining requesters are served in the next burst, starting at the rr pointer.
- Requester 2 raises req during DRAIN -> no ack until DRAIN→IDLE→COLLECT; first grant then goes to 2.
- Reset asserted mid-DRAIN -> next cycle all outputs 0 and state IDLE; grant order restarts from index 0.
- SPI_SCHED_FIXED_PRIO_EN defined, req=1111 held -> requester 0 granted every cycle until it deasserts.
